// File: rtl/kondycjoner_pkg.sv
// Shared types and bit positions for the external-interrupt conditioner.
package kondycjoner_pkg;

  // Edge-qualification mode held in cfg bits [1:0]
  typedef enum logic [1:0] {
    TRYB_WYL    = 2'b00,
    TRYB_NARAST = 2'b01,
    TRYB_OPAD   = 2'b10,
    TRYB_OBA    = 2'b11
  } tryb_t;

  // cfg_data bit positions
  localparam int unsigned CFG_MODE_LSB   = 0;
  localparam int unsigned CFG_MODE_MSB   = 1;
  localparam int unsigned CFG_CLR_CNT    = 6;
  localparam int unsigned CFG_W1C_MISSED = 7;

  // status bit positions
  localparam int unsigned ST_MODE_LSB = 0;
  localparam int unsigned ST_LEVEL    = 5;
  localparam int unsigned ST_PENDING  = 6;
  localparam int unsigned ST_MISSED   = 7;

  // True when a transition to new_level is an edge of interest in mode tryb
  function automatic logic tryb_pasuje(input tryb_t tryb, input logic new_level);
    logic r;
    unique case (tryb)
      TRYB_WYL:    r = 1'b0;
      TRYB_NARAST: r = new_level;
      TRYB_OPAD:   r = ~new_level;
      TRYB_OBA:    r = 1'b1;
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/kondycjoner_przerwania_filtr_drgan.sv
// Pin synchroniser plus debounce filter. Emits the accepted level and a
// one-cycle pulse in the cycle a new level is accepted.
module filtr_drgan #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic level_o,
  output logic event_o
);

  // The counter/level registers sample the chain output, so they act as the
  // final synchroniser stage; this keeps acceptance on edge
  // SYNC_STAGES + DEBOUNCE_CYCLES - 1 after the first sampling edge.
  localparam int unsigned ChainLen = SYNC_STAGES - 1;
  localparam int unsigned CntW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [ChainLen-1:0] sync_q, sync_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                s;

  // Shift chain next state
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = pin_i;
    for (int i = 1; i < int'(ChainLen); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign s = sync_q[ChainLen-1];

  // Debounce: count consecutive cycles that disagree with the accepted level
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    event_o = 1'b0;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      level_d = s;
      cnt_d   = '0;
      event_o = 1'b1;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Filter state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= {ChainLen{RESET_LEVEL}};
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/kondycjoner_przerwania.sv
// External-interrupt conditioner: debounced pin, programmable edge detect,
// pending latch with acknowledge. Optional event counter enabled by the
// macro KONDYCJONER_LICZNIK_ZDARZEN_EN (adds port event_count).
module kondycjoner_przerwania
  import kondycjoner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pin_in,
  input  logic       cfg_we,
  input  logic [7:0] cfg_data,
  input  logic       int_ack,
  output logic       int_req,
  output logic [7:0] status
`ifdef KONDYCJONER_LICZNIK_ZDARZEN_EN
  ,
  output logic [7:0] event_count
`endif
);

  logic  level, trans, qual;
  tryb_t mode_q, mode_d, new_mode;
  logic  pending_q, pending_d;
  logic  missed_q, missed_d;

  filtr_drgan #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (RESET_LEVEL)
  ) u_filtr (
    .clk_i  (clk),
    .rst_ni (rst),
    .pin_i  (pin_in),
    .level_o(level),
    .event_o(trans)
  );

  // A transition always lands on the inverse of the current accepted level
  assign qual     = trans & tryb_pasuje(mode_q, ~level);
  assign new_mode = tryb_t'(cfg_data[CFG_MODE_MSB:CFG_MODE_LSB]);

  // Pending/missed/mode next state; a missed-set overrides a same-cycle W1C
  always_comb begin
    mode_d    = mode_q;
    pending_d = pending_q;
    missed_d  = missed_q;
    if (cfg_we && cfg_data[CFG_W1C_MISSED]) begin
      missed_d = 1'b0;
    end
    if (qual) begin
      if (pending_q && !int_ack) begin
        missed_d = 1'b1;
      end
      pending_d = 1'b1;
    end else if (int_ack) begin
      pending_d = 1'b0;
    end
    if (cfg_we) begin
      mode_d = new_mode;
      if (new_mode == TRYB_WYL) begin
        pending_d = 1'b0;
      end
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= TRYB_WYL;
      pending_q <= 1'b0;
      missed_q  <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      pending_q <= pending_d;
      missed_q  <= missed_d;
    end
  end

  assign int_req = pending_q;
  assign status  = {missed_q, pending_q, level, 3'b000, mode_q};

`ifdef KONDYCJONER_LICZNIK_ZDARZEN_EN
  logic [7:0] evc_q, evc_d;
  logic       unused_cfg;
  assign unused_cfg = ^cfg_data[5:2];

  // Clear first so a same-cycle qualified edge lands on 1
  always_comb begin
    evc_d = evc_q;
    if (cfg_we && cfg_data[CFG_CLR_CNT]) begin
      evc_d = '0;
    end
    if (qual) begin
      evc_d = evc_d + 8'd1;
    end
  end

  // Event counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evc_q <= '0;
    end else begin
      evc_q <= evc_d;
    end
  end

  assign event_count = evc_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^cfg_data[6:2];
`endif

endmodule
